serial_adder: RTL



---
 rtl/arith_pkg.sv | 19 +
 rtl/full_adder.sv | 23 ++
 rtl/serial_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic cells: controller states,
// legal operand width range and the bit-counter sizing helper.
package arith_pkg;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

    // Counter runs 0..width-1; sized for width+1 so width=1 still gets one bit.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder built from two half-adder stages.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha1_s;
    logic ha1_c;
    logic ha2_c;

    // First half adder combines the operand bits, second folds in the carry.
    always_comb begin
        ha1_s = a ^ b;
        ha1_c = a & b;
        sum   = ha1_s ^ cin;
        ha2_c = ha1_s & cin;
        cout  = ha1_c | ha2_c;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// start/busy/done handshake with the result held until the next completion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; operands and carry-in captured on start
// SHIFT | one bit per clock through the full adder, WIDTH cycles
// DONE  | one-cycle done pulse; sum/cout already updated
module serial_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject out-of-range widths at elaboration.
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    sa_state_e        state_q;
    sa_state_e        state_d;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_nxt;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_bit;

    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sum  (fa_s),
        .cout (fa_c)
    );

    assign last_bit = (cnt_q == CNT_LAST);
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);

    // New sum bits enter at the MSB so after WIDTH shifts bit 0 is the LSB.
    always_comb begin
        sum_sh_nxt            = sum_sh >> 1;
        sum_sh_nxt[WIDTH-1]   = fa_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_sh  <= sum_sh_nxt;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    // The published result only moves on the edge into DONE.
                    if (last_bit) begin
                        sum  <= sum_sh_nxt;
                        cout <= fa_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
